// File: rtl/gsau_ctrl_v2.sv
// GSAU control unit: sequences weight-load and compute instructions into the
// systolic array and returns results to the WB buffer in issue order.
module gsau_ctrl_v2 #(
    parameter int DW        = 512,
    parameter int TAGW      = 8,
    parameter int TAG_DEPTH = 4,
    parameter int WROWS     = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DW-1:0]                veg_vdata1,
    input  logic [DW-1:0]                veg_vdata2,
    input  logic                         veg_valid,
    output logic                         veg_ready,
    input  logic                         sb_valid,
    input  logic                         sb_weight,
    input  logic [TAGW-1:0]              sb_vdst,
    output logic                         sb_ready,
    output logic [DW-1:0]                sa_array_in,
    output logic [DW-1:0]                sa_array_in_partials,
    output logic                         sa_input_en,
    output logic                         sa_weight_en,
    output logic                         sa_partial_en,
    input  logic                         sa_fifo_has_space,
    input  logic [DW-1:0]                sa_array_output,
    input  logic                         sa_out_valid,
    output logic                         sa_output_ready,
    output logic [DW-1:0]                wb_psum,
    output logic [TAGW-1:0]              wb_wbdst,
    output logic                         wb_valid,
    input  logic                         wb_output_ready,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         err_orphan,
    output logic [1:0]                   fsm_state
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int OW = PW + 1;
    localparam int RW = (WROWS > 1) ? $clog2(WROWS) : 1;
    localparam logic [OW-1:0] DEPTH_C  = OW'(TAG_DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(WROWS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDRAIN = 2'd1,
        WLOAD  = 2'd2,
        CFEED  = 2'd3
    } state_t;

    state_t           state;
    logic [RW-1:0]    row_cnt;
    logic [TAGW-1:0]  vdst_q;

    logic [TAGW-1:0]  tag_mem [TAG_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    count;

    logic fifo_full, fifo_empty, drained;
    logic beat, w_beat, c_beat;
    logic res_acc, push, pop, orphan;

    assign fsm_state   = state;
    assign outstanding = count;
    assign fifo_full   = (count == DEPTH_C);
    assign fifo_empty  = (count == '0);
    assign drained     = fifo_empty && !wb_valid;

    // Every channel transfers on a cycle where valid & ready are both high;
    // ready never depends on the same channel's valid.
    always_comb begin
        sb_ready  = (state == IDLE);
        veg_ready = 1'b0;
        case (state)
            WLOAD:   veg_ready = 1'b1;
            CFEED:   veg_ready = sa_fifo_has_space && !fifo_full;
            default: veg_ready = 1'b0;
        endcase
    end

    assign beat   = veg_valid && veg_ready;
    assign w_beat = beat && (state == WLOAD);
    assign c_beat = beat && (state == CFEED);

    assign sa_weight_en         = w_beat;
    assign sa_input_en          = c_beat;
    assign sa_partial_en        = c_beat;
    assign sa_array_in          = (w_beat || c_beat) ? veg_vdata1 : '0;
    assign sa_array_in_partials = c_beat ? veg_vdata2 : '0;

    assign sa_output_ready = !wb_valid || wb_output_ready;
    assign res_acc         = sa_out_valid && sa_output_ready;
    // Push is gated on pre-pop occupancy through veg_ready, so a full FIFO
    // never accepts a beat even when a result leaves in the same cycle.
    assign push            = c_beat;
    assign pop             = res_acc && !fifo_empty;
    assign orphan          = res_acc && fifo_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            row_cnt <= '0;
            vdst_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sb_valid) begin
                        if (sb_weight) begin
                            row_cnt <= '0;
                            state   <= drained ? WLOAD : WDRAIN;
                        end else begin
                            vdst_q <= sb_vdst;
                            state  <= CFEED;
                        end
                    end
                end
                WDRAIN: begin
                    if (drained) state <= WLOAD;
                end
                WLOAD: begin
                    if (w_beat) begin
                        row_cnt <= row_cnt + RW'(1);
                        if (row_cnt == LAST_ROW) state <= IDLE;
                    end
                end
                CFEED: begin
                    if (c_beat) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) tag_mem[wr_ptr] <= vdst_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    // An orphan result counts as no transfer for the output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_psum    <= '0;
            wb_wbdst   <= '0;
            wb_valid   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (pop) begin
                wb_psum  <= sa_array_output;
                wb_wbdst <= tag_mem[rd_ptr];
                wb_valid <= 1'b1;
            end else if (wb_output_ready) begin
                wb_valid <= 1'b0;
            end
            if (orphan) err_orphan <= 1'b1;
        end
    end

endmodule
